// File: rtl/elevator_pkg.sv
// elevator_pkg: floor codes, scheduler state encoding and default timing
// shared by the elevator call scheduler and its target selector.
package elevator_pkg;
  localparam int N_FLOORS = 3;
  localparam int DEF_DOOR_CYCLES = 8;
  localparam logic [1:0] FLOOR1 = 2'b00;
  localparam logic [1:0] FLOOR2 = 2'b01;
  localparam logic [1:0] FLOOR3 = 2'b10;
  localparam logic [1:0] FLOOR_NONE = 2'b11;
  typedef enum logic [1:0] {IDLE, CLOSE, MOVE, OPEN} state_e;
  function automatic logic [N_FLOORS-1:0] floor_bit(input logic [1:0] f);
    return (f == FLOOR_NONE) ? '0 : N_FLOORS'(1) << f;
  endfunction
endpackage

// File: rtl/scan_target_sel.sv
// scan_target_sel: combinational SCAN choice of the next floor to serve
// from the pending calls, the car position and the current direction.
module scan_target_sel
  import elevator_pkg::*;
(
  input  logic [N_FLOORS-1:0] pending,
  input  logic [1:0]          cur_floor,
  input  logic                dir_up,
  output logic [1:0]          next_target,
  output logic                next_dir,
  output logic                valid
);
  logic [N_FLOORS-1:0] above, below;
  logic up_v, dn_v, go_up;
  always_comb begin
    above = N_FLOORS'(6) << cur_floor;
    below = ~above & ~floor_bit(cur_floor);
    up_v = |(pending & above);
    dn_v = |(pending & below);
    go_up = dir_up ? up_v : (up_v && !dn_v);
    valid = (cur_floor != FLOOR_NONE) && (up_v || dn_v);
    next_dir = go_up || (!dn_v && dir_up);
    next_target = go_up ? ((cur_floor == FLOOR1 && pending[1]) ? FLOOR2 : FLOOR3)
                        : ((cur_floor == FLOOR3 && pending[1]) ? FLOOR2 : FLOOR1);
  end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: latches floor calls, picks the next floor (SCAN) and
// sequences door/car for a 3-floor car. Optional MOVE watchdog: SCHED_WATCHDOG_EN.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int CNT_W = 4
`ifdef SCHED_WATCHDOG_EN
  , parameter int MOVE_TIMEOUT = 15
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call_in,
  input  logic [1:0]          cur_floor,
  output logic [1:0]          target,
  output logic                door_closed,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending,
  output logic                busy,
  output logic                fault
);
  localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_CYCLES);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_e state_q, state_d;
  logic [N_FLOORS-1:0] pend_q, pend_d, clr;
  logic [1:0] tgt_q, tgt_d, sel_t;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, door_q, busy_q, sel_dir, sel_v, cur_ok, hold;
  assign cur_ok = cur_floor != FLOOR_NONE;
  scan_target_sel u_sel (
    .pending    (pend_q),
    .cur_floor  (cur_floor),
    .dir_up     (dir_q),
    .next_target(sel_t),
    .next_dir   (sel_dir),
    .valid      (sel_v)
  );
`ifdef SCHED_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MOVE_TIMEOUT);
  logic fault_q, fault_d;
  assign hold = fault_q;
  assign fault = fault_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) fault_q <= 1'b0;
    else fault_q <= fault_d;
`else
  assign hold = 1'b0;
  assign fault = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    clr = '0;
`ifdef SCHED_WATCHDOG_EN
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: if (!hold && cur_ok && |pend_q) begin
        if (|(pend_q & floor_bit(cur_floor))) begin
          state_d = OPEN;
          tgt_d = cur_floor;
          cnt_d = DOOR_LD;
          clr = floor_bit(cur_floor);
        end else if (sel_v) begin
          state_d = CLOSE;
          tgt_d = sel_t;
          dir_d = sel_dir;
          cnt_d = DOOR_LD;
        end
      end
      CLOSE: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = MOVE;
      end
      MOVE: if (cur_floor == tgt_q) begin
        state_d = OPEN;
        cnt_d = DOOR_LD;
        clr = floor_bit(tgt_q);
      end else begin
        // the middle floor is the only one that can lie between car and target
        if (cur_ok && pend_q[1] && ((cur_floor == FLOOR1 && tgt_q == FLOOR3) ||
            (cur_floor == FLOOR3 && tgt_q == FLOOR1))) tgt_d = FLOOR2;
`ifdef SCHED_WATCHDOG_EN
        if (cnt_q == TIMEOUT) begin
          fault_d = 1'b1;
          state_d = IDLE;
          cnt_d = '0;
        end else cnt_d = cnt_q + ONE;
`endif
      end
      OPEN: if (|(call_in & floor_bit(tgt_q))) begin
        cnt_d = DOOR_LD;
        clr = floor_bit(tgt_q);
      end else begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = IDLE;
      end
    endcase
    pend_d = (pend_q | call_in) & ~clr;
`ifdef SCHED_WATCHDOG_EN
    if (fault_d) pend_d = '0;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      tgt_q <= FLOOR1;
      dir_q <= 1'b1;
      cnt_q <= '0;
      door_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      tgt_q <= tgt_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      door_q <= state_d == MOVE;
      busy_q <= state_d != IDLE;
    end
  assign target = tgt_q;
  assign door_closed = door_q;
  assign dir_up = dir_q;
  assign pending = pend_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: random calls and a simple moving car, checked every
// cycle against a floor-level SCAN reference model through a scoreboard queue.
module tb_elevator_call_scheduler;
  localparam int D = 8;
  localparam int TO = 15;
`ifdef SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] call_in = '0;
  logic [1:0] cur_floor = '0;
  logic [1:0] target;
  logic door_closed, dir_up, busy, fault;
  logic [2:0] pending;
  elevator_call_scheduler dut (
    .clk(clk), .rst(rst), .call_in(call_in), .cur_floor(cur_floor), .target(target),
    .door_closed(door_closed), .dir_up(dir_up), .pending(pending), .busy(busy), .fault(fault)
  );
  always #5 clk = ~clk;
  typedef enum {PARKED, CLOSING, TRAVEL, DOORS_OPEN} phase_e;
  typedef struct {
    logic [1:0] tgt;
    logic door, dir, busy, fault;
    logic [2:0] pend;
  } exp_t;
  exp_t sb[$];
  phase_e ph = PARKED;
  int m_tgt = 0, timer = 0, travel = 0;
  bit m_dir = 1'b1, m_fault = 1'b0;
  bit [2:0] m_pend = '0;
  int checks = 0, errors = 0;
  int car = 0, car_t = 0;
  bit stall = 1'b0, glitch = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // nearest pending floor ahead in the travel direction, else nearest behind
  function automatic int pick(input bit [2:0] p, input int cur, input bit up, output bit nd);
    int bu = -1, bd = -1;
    for (int f = 0; f < 3; f++) if (p[f]) begin
      if (f > cur && (bu < 0 || f - cur < bu - cur)) bu = f;
      if (f < cur && (bd < 0 || cur - f < cur - bd)) bd = f;
    end
    if (up ? bu >= 0 : bd < 0) begin
      nd = 1'b1;
      return bu;
    end
    nd = 1'b0;
    return bd;
  endfunction
  always @(posedge clk) begin : model
    int cur, t0;
    bit [2:0] clr;
    bit nd;
    exp_t e;
    cur = int'(cur_floor);
    clr = '0;
    if (!rst) begin
      ph = PARKED; m_tgt = 0; timer = 0; m_dir = 1'b1; m_fault = 1'b0; m_pend = '0;
    end else begin
      case (ph)
        PARKED: if (!m_fault && cur != 3 && m_pend != 0) begin
          if (m_pend[cur]) begin
            ph = DOORS_OPEN; m_tgt = cur; timer = D; clr[cur] = 1'b1;
          end else begin
            m_tgt = pick(m_pend, cur, m_dir, nd); m_dir = nd; ph = CLOSING; timer = D;
          end
        end
        CLOSING: begin
          timer--;
          if (timer == 0) begin ph = TRAVEL; travel = 1; end
        end
        TRAVEL: if (cur == m_tgt) begin
          ph = DOORS_OPEN; timer = D; clr[m_tgt] = 1'b1;
        end else begin
          t0 = m_tgt;
          if (cur != 3) for (int f = 0; f < 3; f++)
            if (m_pend[f] && ((cur < f && f < t0) || (t0 < f && f < cur)) &&
                (m_tgt == t0 || (f > cur ? f - cur : cur - f) < (m_tgt > cur ? m_tgt - cur : cur - m_tgt)))
              m_tgt = f;
          if (WD && travel > TO) begin m_fault = 1'b1; ph = PARKED; end
          else travel++;
        end
        DOORS_OPEN: if (call_in[m_tgt]) begin
          timer = D; clr[m_tgt] = 1'b1;
        end else begin
          timer--;
          if (timer == 0) ph = PARKED;
        end
      endcase
      m_pend = (m_pend | call_in) & ~clr;
      if (m_fault) m_pend = '0;
    end
    e.tgt = 2'(m_tgt); e.door = ph == TRAVEL; e.dir = m_dir; e.busy = ph != PARKED;
    e.fault = m_fault; e.pend = m_pend;
    sb.push_back(e);
  end
  always @(negedge clk) if (sb.size() > 0) begin : monitor
    exp_t e;
    e = sb.pop_front();
    check("target", 32'(target), 32'(e.tgt));
    check("door_closed", 32'(door_closed), 32'(e.door));
    check("dir_up", 32'(dir_up), 32'(e.dir));
    check("pending", 32'(pending), 32'(e.pend));
    check("busy", 32'(busy), 32'(e.busy));
    check("fault", 32'(fault), 32'(e.fault));
  end
  // car creeps one floor every 3 cycles toward the model target while the door is closed
  task automatic tick();
    @(negedge clk);
    #1;
    if (!stall && ph == TRAVEL && car != m_tgt) begin
      car_t++;
      if (car_t >= 3) begin
        car += (m_tgt > car) ? 1 : -1;
        car_t = 0;
      end
    end
    cur_floor = (glitch && $urandom_range(0, 24) == 0) ? 2'b11 : 2'(car);
  endtask
  initial begin
    int lat;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    call_in = 3'b100;
    tick();
    call_in = '0;
    lat = 1;
    while (door_closed !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check("call_to_door_latency", 32'(lat), 32'(D + 2));
    for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
    check("served_then_idle", 32'(busy), 32'd0);
    glitch = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      call_in = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    glitch = 1'b0;
    call_in = '0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    call_in = (car == 0) ? 3'b100 : 3'b001;
    stall = 1'b1;
    tick();
    call_in = '0;
    for (int i = 0; i < 30 && door_closed !== 1'b1; i++) tick();
    check("stall_move_entered", 32'(door_closed), 32'd1);
    repeat (20) tick();
    check("stall_fault", 32'(fault), 32'(WD));
    check("stall_door", 32'(door_closed), 32'(!WD));
    rst = 1'b0;
    tick();
    check("fault_cleared_by_reset", 32'(fault), 32'd0);
    rst = 1'b1;
    stall = 1'b0;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
